load_unit_simple: RTL and testbench
===================================

Name: load_unit_simple

Overview:
- Read-side counterpart of the LSU store path: accepts one load from the LSU issue queue at a time.
- Requests address translation and checks the store buffer for a page-offset hazard.
- Issues a two-phase (index, then tag) D$ read, then realigns and sign/zero-extends the returned data.
- Writes the result back with the load's transaction ID.
- Exactly one load is outstanding at a time.

Parameters:
- XLEN, 64, data width.
- VLEN, 39, virtual address width.
- PLEN, 56, physical address width.
- TRANS_ID_BITS, 3, width of the scoreboard transaction ID.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush
- valid_i  in  1  load available at head of issue queue
- vaddr_i  in  VLEN  load virtual address
- op_i  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=LWU 6=LD
- trans_id_i  in  TRANS_ID_BITS  load transaction ID
- pop_ld_o  out  1  load consumed; issue queue advances
- translation_req_o  out  1  MMU request
- vaddr_o  out  VLEN  equals vaddr_i
- paddr_i  in  PLEN  translated address
- dtlb_hit_i  in  1  translation valid in the same cycle
- ex_valid_i  in  1  translation/access exception
- page_offset_o  out  12  equals vaddr_i[11:0]
- page_offset_matches_i  in  1  store buffer holds an uncommitted store to the same offset
- req_o  out  1  D$ index request
- addr_index_o  out  12  equals vaddr_i[11:0]
- data_size_o  out  2  0/1/2/3 = byte/half/word/double
- gnt_i  in  1  D$ index grant
- tag_valid_o  out  1  tag phase
- addr_tag_o  out  PLEN-12  equals paddr_i[PLEN-1:12]
- kill_req_o  out  1  abort the granted request
- rvalid_i  in  1  read data valid
- rdata_i  in  XLEN  64-bit aligned read data
- valid_o  out  1  writeback
- trans_id_o  out  TRANS_ID_BITS  latched ID
- result_o  out  XLEN  load result
- ex_valid_o  out  1  writeback carries an exception

Behaviour:
- Reset: state IDLE, all registers 0, all outputs 0. Outputs are combinational from state; inputs are held until pop_ld_o.
- On accept (leaving IDLE/WAIT_PAGE_OFFSET with req_o=1), latch op_i, vaddr_i[2:0] and trans_id_i.
- IDLE, valid_i && !flush_i:
  - page_offset_matches_i -> WAIT_PAGE_OFFSET, no request.
  - otherwise req_o=1 and translation_req_o=1; gnt_i -> SEND_TAG, else -> WAIT_GNT.
- WAIT_PAGE_OFFSET: once page_offset_matches_i=0, behaves exactly like IDLE accept.
- WAIT_GNT: req_o=1, translation_req_o=1; gnt_i -> SEND_TAG.
- SEND_TAG: translation_req_o=1. Priority order:
  1. ex_valid_i: kill_req_o=1, valid_o=1, ex_valid_o=1, pop_ld_o=1, result_o=0 -> IDLE.
  2. dtlb_hit_i: tag_valid_o=1, pop_ld_o=1 -> WAIT_RVALID.
  3. otherwise: kill_req_o=1 -> WAIT_TRANSLATION.
- WAIT_TRANSLATION: translation_req_o=1; dtlb_hit_i -> IDLE. The load is re-issued from scratch and was never popped.
- WAIT_RVALID: on rvalid_i, valid_o=1 (same cycle, combinational result) -> IDLE.
- Result: shifted = rdata_i >> (8*offset_q); extend bits [7:0], [15:0] or [31:0] per op_q (signed for LB/LH/LW, zero for LBU/LHU/LWU); LD passes shifted through.
- Misaligned addresses are not checked here; the MMU flags them via ex_valid_i.
- Flush:
  - IDLE/WAIT_PAGE_OFFSET/WAIT_GNT/WAIT_TRANSLATION -> IDLE, no kill needed.
  - SEND_TAG: kill_req_o=1, no pop, no valid_o -> IDLE.
  - WAIT_RVALID without rvalid_i -> DROP. DROP waits for rvalid_i, discards it (valid_o=0) -> IDLE.
  - WAIT_RVALID with rvalid_i in the same cycle: data discarded, valid_o=0 -> IDLE.
  - flush_i overrides every valid_o/pop_ld_o in that cycle.
- A new load is never accepted in the cycle valid_o is asserted (minimum 3-cycle load-to-load spacing).
- Reset mid-operation returns to IDLE; a pending D$ response after reset is the cache's responsibility.

Test Plan:
- LW, vaddr=0x1004, gnt_i immediately, hit next cycle, rdata_i=0x8000_0000_0000_0000 -> req_o at cycle 0, tag_valid_o at 1, valid_o on the rvalid_i cycle, result_o=0xFFFF_FFFF_8000_0000, trans_id_o matches.
- LBU, offset 7, rdata_i=0xAB00_0000_0000_0000 -> result_o=0xAB. LB with the same data -> result_o=0xFFFF_FFFF_FFFF_FFAB.
- page_offset_matches_i held 3 cycles -> no req_o for 3 cycles, then a normal request.
- TLB miss in SEND_TAG -> kill_req_o=1, no pop; dtlb_hit_i after 5 cycles -> load re-requests and completes correctly.
- ex_valid_i in SEND_TAG -> valid_o=1, ex_valid_o=1, pop_ld_o=1, kill_req_o=1 in one cycle.
- flush_i in WAIT_RVALID, rvalid_i 2 cycles later -> valid_o stays 0; the next load completes normally.

Source files
------------

// File: rtl/load_unit_simple.sv
// Single-outstanding load path: translation and store-hazard check, two-phase D$ read,
// then realignment and sign/zero extension of the returned doubleword.
module load_unit_simple #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned VLEN          = 39,
    parameter int unsigned PLEN          = 56,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic [VLEN-1:0]          vaddr_i,
    input  logic [2:0]               op_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     pop_ld_o,
    output logic                     translation_req_o,
    output logic [VLEN-1:0]          vaddr_o,
    input  logic [PLEN-1:0]          paddr_i,
    input  logic                     dtlb_hit_i,
    input  logic                     ex_valid_i,
    output logic [11:0]              page_offset_o,
    input  logic                     page_offset_matches_i,
    output logic                     req_o,
    output logic [11:0]              addr_index_o,
    output logic [1:0]               data_size_o,
    input  logic                     gnt_i,
    output logic                     tag_valid_o,
    output logic [PLEN-13:0]         addr_tag_o,
    output logic                     kill_req_o,
    input  logic                     rvalid_i,
    input  logic [XLEN-1:0]          rdata_i,
    output logic                     valid_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic [XLEN-1:0]          result_o,
    output logic                     ex_valid_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PAGE_OFFSET,
        WAIT_GNT,
        SEND_TAG,
        WAIT_TRANSLATION,
        WAIT_RVALID,
        DROP
    } state_e;

    state_e                   state_q, state_d;
    logic [2:0]               op_q, op_d;
    logic [2:0]               offset_q, offset_d;
    logic [TRANS_ID_BITS-1:0] trans_id_q, trans_id_d;
    logic [XLEN-1:0]          shifted;
    logic [XLEN-1:0]          load_result;

    // The physical page offset is identical to the virtual one, so only the tag bits matter here.
    logic unused_paddr_offset;
    assign unused_paddr_offset = ^paddr_i[11:0];

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] data, input logic [2:0] op);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        b = data[7:0];
        h = data[15:0];
        w = data[31:0];
        case (op)
            3'd0:    return XLEN'(b);
            3'd1:    return XLEN'(data[7:0]);
            3'd2:    return XLEN'(h);
            3'd3:    return XLEN'(data[15:0]);
            3'd4:    return XLEN'(w);
            3'd5:    return XLEN'(data[31:0]);
            default: return data;
        endcase
    endfunction

    assign vaddr_o       = vaddr_i;
    assign page_offset_o = vaddr_i[11:0];
    assign addr_index_o  = vaddr_i[11:0];
    assign addr_tag_o    = paddr_i[PLEN-1:12];
    assign data_size_o   = op_i[2:1];
    assign trans_id_o    = trans_id_q;

    assign shifted     = rdata_i >> {offset_q, 3'b000};
    assign load_result = extend(shifted, op_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_q       <= '0;
            offset_q   <= '0;
            trans_id_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            offset_q   <= offset_d;
            trans_id_q <= trans_id_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        offset_d          = offset_q;
        trans_id_d        = trans_id_q;
        req_o             = 1'b0;
        translation_req_o = 1'b0;
        tag_valid_o       = 1'b0;
        kill_req_o        = 1'b0;
        pop_ld_o          = 1'b0;
        valid_o           = 1'b0;
        ex_valid_o        = 1'b0;
        result_o          = '0;

        case (state_q)
            IDLE, WAIT_PAGE_OFFSET: begin
                if (flush_i || !valid_i) begin
                    state_d = IDLE;
                end else if (page_offset_matches_i) begin
                    // An older store to the same offset must drain before we may read.
                    state_d = WAIT_PAGE_OFFSET;
                end else begin
                    req_o             = 1'b1;
                    translation_req_o = 1'b1;
                    op_d              = op_i;
                    offset_d          = vaddr_i[2:0];
                    trans_id_d        = trans_id_i;
                    state_d           = gnt_i ? SEND_TAG : WAIT_GNT;
                end
            end

            WAIT_GNT: begin
                req_o             = 1'b1;
                translation_req_o = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (gnt_i) begin
                    state_d = SEND_TAG;
                end
            end

            SEND_TAG: begin
                translation_req_o = 1'b1;
                if (flush_i) begin
                    kill_req_o = 1'b1;
                    state_d    = IDLE;
                end else if (ex_valid_i) begin
                    kill_req_o = 1'b1;
                    valid_o    = 1'b1;
                    ex_valid_o = 1'b1;
                    pop_ld_o   = 1'b1;
                    state_d    = IDLE;
                end else if (dtlb_hit_i) begin
                    tag_valid_o = 1'b1;
                    pop_ld_o    = 1'b1;
                    state_d     = WAIT_RVALID;
                end else begin
                    // TLB miss: abandon the cache access and replay the whole load once translated.
                    kill_req_o = 1'b1;
                    state_d    = WAIT_TRANSLATION;
                end
            end

            WAIT_TRANSLATION: begin
                translation_req_o = 1'b1;
                if (flush_i || dtlb_hit_i) begin
                    state_d = IDLE;
                end
            end

            WAIT_RVALID: begin
                if (rvalid_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        valid_o  = 1'b1;
                        result_o = load_result;
                    end
                end else if (flush_i) begin
                    state_d = DROP;
                end
            end

            DROP: begin
                // The cache still owes us one beat; swallow it silently.
                if (rvalid_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_unit_simple.sv
// Scoreboard bench for load_unit_simple: a driver plays issue queue, MMU and D$, a monitor
// checks every writeback against responses predicted from the load semantics.
module tb_load_unit_simple;
    localparam int XLEN = 64;
    localparam int VLEN = 39;
    localparam int PLEN = 56;
    localparam int TIDW = 3;

    logic              clk = 1'b0;
    logic              rst_ni, flush_i, valid_i;
    logic [VLEN-1:0]   vaddr_i;
    logic [2:0]        op_i;
    logic [TIDW-1:0]   trans_id_i;
    logic              pop_ld_o, translation_req_o;
    logic [VLEN-1:0]   vaddr_o;
    logic [PLEN-1:0]   paddr_i;
    logic              dtlb_hit_i, ex_valid_i;
    logic [11:0]       page_offset_o;
    logic              page_offset_matches_i;
    logic              req_o;
    logic [11:0]       addr_index_o;
    logic [1:0]        data_size_o;
    logic              gnt_i, tag_valid_o;
    logic [PLEN-13:0]  addr_tag_o;
    logic              kill_req_o, rvalid_i;
    logic [XLEN-1:0]   rdata_i;
    logic              valid_o;
    logic [TIDW-1:0]   trans_id_o;
    logic [XLEN-1:0]   result_o;
    logic              ex_valid_o;

    always #5 clk = ~clk;

    load_unit_simple #(.XLEN(XLEN), .VLEN(VLEN), .PLEN(PLEN), .TRANS_ID_BITS(TIDW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .vaddr_i(vaddr_i),
        .op_i(op_i), .trans_id_i(trans_id_i), .pop_ld_o(pop_ld_o),
        .translation_req_o(translation_req_o), .vaddr_o(vaddr_o), .paddr_i(paddr_i),
        .dtlb_hit_i(dtlb_hit_i), .ex_valid_i(ex_valid_i), .page_offset_o(page_offset_o),
        .page_offset_matches_i(page_offset_matches_i), .req_o(req_o), .addr_index_o(addr_index_o),
        .data_size_o(data_size_o), .gnt_i(gnt_i), .tag_valid_o(tag_valid_o), .addr_tag_o(addr_tag_o),
        .kill_req_o(kill_req_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .valid_o(valid_o),
        .trans_id_o(trans_id_o), .result_o(result_o), .ex_valid_o(ex_valid_o)
    );

    typedef struct packed {
        logic [TIDW-1:0] tid;
        logic            ex;
        logic [63:0]     res;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Load semantics: pick the addressed bytes, then sign- or zero-fill the rest.
    function automatic logic [63:0] ref_load(input logic [2:0] op, input logic [2:0] off,
                                             input logic [63:0] rd);
        int          nb;
        logic [63:0] v, mask;
        nb = 1 << (int'(op) / 2);
        v  = rd >> (8 * int'(off));
        if (nb < 8) begin
            mask = (64'd1 << (8 * nb)) - 64'd1;
            v    = v & mask;
            if ((int'(op) % 2 == 0) && v[8*nb-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic drive_defaults();
        rst_ni                = 1'b1;
        flush_i               = 1'b0;
        valid_i               = 1'b0;
        page_offset_matches_i = 1'b0;
        gnt_i                 = 1'b0;
        dtlb_hit_i            = 1'b0;
        ex_valid_i            = 1'b0;
        rvalid_i              = 1'b0;
    endtask

    task automatic present(input logic [2:0] op, input logic [VLEN-1:0] va, input logic [TIDW-1:0] tid);
        valid_i    = 1'b1;
        vaddr_i    = va;
        op_i       = op;
        trans_id_i = tid;
    endtask

    // fmode: 0 normal, 1 flush in WAIT_RVALID, 2 flush in SEND_TAG, 3 reset in WAIT_RVALID
    task automatic run_load(input logic [2:0] op, input logic [VLEN-1:0] va, input logic [TIDW-1:0] tid,
                            input logic [63:0] rd, input logic [63:0] expv, input int pom, input int gdly,
                            input int miss, input bit exc, input int rvdly, input int fmode);
        logic [PLEN-1:0] pa;
        exp_t            e;
        pa = {20'($urandom), 24'($urandom), va[11:0]};
        for (int i = 0; i < pom; i++) begin
            @(negedge clk); drive_defaults(); present(op, va, tid); page_offset_matches_i = 1'b1;
            #1;
            chk("pom_no_req", 64'(req_o), 64'd0);
            chk("pom_no_xlate", 64'(translation_req_o), 64'd0);
        end
        for (int i = 0; i <= gdly; i++) begin
            @(negedge clk); drive_defaults(); present(op, va, tid); gnt_i = (i == gdly);
            #1;
            chk("idx_req", 64'(req_o), 64'd1);
            chk("idx_xlate_req", 64'(translation_req_o), 64'd1);
            if (i == 0) begin
                chk("idx_addr", 64'(addr_index_o), 64'(va[11:0]));
                chk("idx_size", 64'(data_size_o), 64'(int'(op) / 2));
            end
        end
        @(negedge clk); drive_defaults(); present(op, va, tid); paddr_i = pa;
        if (fmode == 2) begin
            flush_i = 1'b1; dtlb_hit_i = 1'b1;
            #1;
            chk("flush_tag_kill", 64'(kill_req_o), 64'd1);
            chk("flush_tag_pop", 64'(pop_ld_o), 64'd0);
            chk("flush_tag_valid", 64'(valid_o), 64'd0);
            return;
        end
        if (exc) begin
            ex_valid_i = 1'b1; dtlb_hit_i = 1'($urandom);
            e.tid = tid; e.ex = 1'b1; e.res = 64'd0;
            sb.push_back(e);
            #1;
            chk("exc_kill", 64'(kill_req_o), 64'd1);
            chk("exc_pop", 64'(pop_ld_o), 64'd1);
            chk("exc_valid", 64'(valid_o), 64'd1);
            return;
        end
        if (miss > 0) begin
            #1;
            chk("miss_kill", 64'(kill_req_o), 64'd1);
            chk("miss_pop", 64'(pop_ld_o), 64'd0);
            chk("miss_tag_valid", 64'(tag_valid_o), 64'd0);
            for (int i = 0; i < miss; i++) begin
                @(negedge clk); drive_defaults(); present(op, va, tid); dtlb_hit_i = (i == miss - 1);
                #1;
                chk("miss_xlate_req", 64'(translation_req_o), 64'd1);
                chk("miss_no_req", 64'(req_o), 64'd0);
            end
            run_load(op, va, tid, rd, expv, 0, gdly, 0, exc, rvdly, fmode);
            return;
        end
        dtlb_hit_i = 1'b1;
        #1;
        chk("tag_valid", 64'(tag_valid_o), 64'd1);
        chk("tag_pop", 64'(pop_ld_o), 64'd1);
        chk("tag_kill", 64'(kill_req_o), 64'd0);
        chk("tag_addr", 64'(addr_tag_o), 64'(pa[PLEN-1:12]));
        for (int i = 0; i <= rvdly; i++) begin
            @(negedge clk); drive_defaults();
            rvalid_i = (i == rvdly);
            rdata_i  = (i == rvdly) ? rd : {$urandom, $urandom};
            if (fmode == 1 && i == 0) flush_i = 1'b1;
            if (fmode == 3 && i == 0) rst_ni = 1'b0;
            if (fmode == 0 && i == rvdly) begin
                e.tid = tid; e.ex = 1'b0; e.res = expv;
                sb.push_back(e);
            end
            #1;
            if (fmode == 0 && i < rvdly) chk("rv_wait_no_valid", 64'(valid_o), 64'd0);
            if (fmode == 3 && i == 0) chk("rst_mid_tid", 64'(trans_id_o), 64'd0);
        end
    endtask

    // Monitor: every writeback must match the oldest predicted response.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid_o: got trans_id %0d result %h, required no writeback",
                             trans_id_o, result_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_trans_id", 64'(trans_id_o), 64'(e.tid));
                    chk("wb_ex_valid", 64'(ex_valid_o), 64'(e.ex));
                    chk("wb_result", result_o, e.res);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]      op, off;
        logic [VLEN-1:0] va;
        logic [63:0]     rd;
        int              r, fmode, pom, miss;

        drive_defaults();
        vaddr_i = '0; op_i = '0; trans_id_i = '0; paddr_i = '0; rdata_i = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", 64'(req_o), 64'd0);
        chk("rst_xlate", 64'(translation_req_o), 64'd0);
        chk("rst_pop", 64'(pop_ld_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_trans_id", 64'(trans_id_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        @(negedge clk); drive_defaults();
        #1;
        chk("idle_kill", 64'(kill_req_o), 64'd0);
        chk("idle_tag_valid", 64'(tag_valid_o), 64'd0);
        chk("idle_ex_valid", 64'(ex_valid_o), 64'd0);

        run_load(3'd4, 39'h1004, 3'd5, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 0, 0, 0, 1'b0, 0, 0);
        run_load(3'd1, 39'h2007, 3'd1, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB, 0, 0, 0, 1'b0, 1, 0);
        run_load(3'd0, 39'h2007, 3'd2, 64'hAB00_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFAB, 0, 1, 0, 1'b0, 0, 0);
        run_load(3'd6, 39'h2000, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3, 0, 0, 1'b0, 0, 0);
        run_load(3'd2, 39'h3006, 3'd4, 64'hBEEF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_BEEF, 0, 0, 5, 1'b0, 1, 0);
        run_load(3'd5, 39'h3000, 3'd6, 64'h1234, 64'd0, 0, 0, 0, 1'b1, 0, 0);
        run_load(3'd6, 39'h4000, 3'd7, 64'h5555, 64'd0, 0, 0, 0, 1'b0, 2, 1);
        run_load(3'd3, 39'h4002, 3'd0, 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001, 0, 0, 0, 1'b0, 0, 0);
        run_load(3'd6, 39'h4008, 3'd1, 64'h7777, 64'd0, 0, 0, 0, 1'b0, 0, 2);
        run_load(3'd5, 39'h0010, 3'd2, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 0, 0, 0, 1'b0, 0, 0);
        run_load(3'd6, 39'h5000, 3'd3, 64'h9999, 64'd0, 0, 0, 0, 1'b0, 2, 3);
        run_load(3'd4, 39'h5004, 3'd4, 64'h7FFF_FFFF_0000_0000, 64'h0000_0000_7FFF_FFFF, 0, 0, 0, 1'b0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            op  = 3'($urandom_range(0, 6));
            off = 3'($urandom_range(0, 7)) & ~3'((1 << (int'(op) / 2)) - 1);
            va  = {4'($urandom), 32'($urandom), off};
            rd  = {$urandom, $urandom};
            pom  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            miss = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
            r = int'($urandom_range(0, 9));
            fmode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            run_load(op, va, 3'($urandom), rd, ref_load(op, off, rd), pom, int'($urandom_range(0, 2)),
                     miss, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), fmode);
        end

        repeat (4) begin
            @(negedge clk); drive_defaults();
        end
        #3;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
